wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Shares one registered writeback/bypass slot among three execution units
//   (MUL=0, DIV=1, LSU=2). Each unit owns a one-entry result buffer. Occupied
//   buffers are arbitrated round-robin, and the winner's entry is registered
//   onto WB_* on the following edge.
//
// Ports
//   clk                      single clock, rising edge
//   rst                      asynchronous, active-high reset
//   flush                    synchronous pipeline flush; drops all buffered work
//   <U>_vld / <U>_PR / <U>_data   requester result (held until accepted)
//   <U>_rdy                  arbiter accepts this cycle (combinational)
//   WB_vld / WB_PR / WB_data registered writeback slot; zeros when invalid
//   pending                  any requester buffer occupied (combinational)
// -----------------------------------------------------------------------------
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        MUL_vld,
    input  logic [5:0]  MUL_PR,
    input  logic [31:0] MUL_data,
    input  logic        DIV_vld,
    input  logic [5:0]  DIV_PR,
    input  logic [31:0] DIV_data,
    input  logic        LSU_vld,
    input  logic [5:0]  LSU_PR,
    input  logic [31:0] LSU_data,
    output logic        MUL_rdy,
    output logic        DIV_rdy,
    output logic        LSU_rdy,
    output logic        WB_vld,
    output logic [5:0]  WB_PR,
    output logic [31:0] WB_data,
    output logic        pending
);

    // Round-robin pick: search order starts at ptr and wraps modulo 3.
    // ptr never holds 3; that encoding falls back to the ptr=0 order.
    function automatic logic [2:0] rr_grant(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] g;
        g = 3'b000;
        case (ptr)
            2'd1: begin
                if (req[1])      g = 3'b010;
                else if (req[2]) g = 3'b100;
                else if (req[0]) g = 3'b001;
                else             g = 3'b000;
            end
            2'd2: begin
                if (req[2])      g = 3'b100;
                else if (req[0]) g = 3'b001;
                else if (req[1]) g = 3'b010;
                else             g = 3'b000;
            end
            default: begin
                if (req[0])      g = 3'b001;
                else if (req[1]) g = 3'b010;
                else if (req[2]) g = 3'b100;
                else             g = 3'b000;
            end
        endcase
        return g;
    endfunction

    logic [2:0]  req_vld_s;
    logic [5:0]  req_pr_s   [3];
    logic [31:0] req_data_s [3];

    logic [2:0]  bvld_r;
    logic [5:0]  bpr_r   [3];
    logic [31:0] bdata_r [3];
    logic [1:0]  ptr_r;

    logic [2:0]  grant_s;
    logic [1:0]  gidx_s;
    logic [1:0]  ptr_next_s;
    logic [2:0]  rdy_s;
    logic [2:0]  load_s;

    logic        wb_vld_r;
    logic [5:0]  wb_pr_r;
    logic [31:0] wb_data_r;

    assign req_vld_s     = {LSU_vld, DIV_vld, MUL_vld};
    assign req_pr_s[0]   = MUL_PR;
    assign req_pr_s[1]   = DIV_PR;
    assign req_pr_s[2]   = LSU_PR;
    assign req_data_s[0] = MUL_data;
    assign req_data_s[1] = DIV_data;
    assign req_data_s[2] = LSU_data;

    // Grant selection, winner index and the pointer value that follows it.
    always_comb begin
        grant_s    = rr_grant(bvld_r, ptr_r);
        gidx_s     = 2'd0;
        ptr_next_s = ptr_r;
        case (grant_s)
            3'b001: begin gidx_s = 2'd0; ptr_next_s = 2'd1; end
            3'b010: begin gidx_s = 2'd1; ptr_next_s = 2'd2; end
            3'b100: begin gidx_s = 2'd2; ptr_next_s = 2'd0; end
            default: begin gidx_s = 2'd0; ptr_next_s = ptr_r; end
        endcase
    end

    // Ready and buffer-load decode. A buffer being drained this cycle can take
    // a new entry on the same edge; PR 0 is accepted but never buffered.
    always_comb begin
        rdy_s  = {3{~flush}} & (~bvld_r | grant_s);
        load_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            load_s[i] = req_vld_s[i] & rdy_s[i] & (req_pr_s[i] != 6'd0);
        end
    end

    // Per-requester result buffers; a same-edge reload wins over the drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvld_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                bpr_r[i]   <= 6'd0;
                bdata_r[i] <= 32'd0;
            end
        end else if (flush) begin
            bvld_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load_s[i]) begin
                    bvld_r[i]  <= 1'b1;
                    bpr_r[i]   <= req_pr_s[i];
                    bdata_r[i] <= req_data_s[i];
                end else if (grant_s[i]) begin
                    bvld_r[i]  <= 1'b0;
                end else begin
                    bvld_r[i]  <= bvld_r[i];
                end
            end
        end
    end

    // Round-robin pointer: advances past the winner, holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 2'd0;
        end else if (flush) begin
            ptr_r <= 2'd0;
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    // Writeback output register; driven to zero whenever no result is granted
    // so bypass consumers never see stale PR/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vld_r  <= 1'b0;
            wb_pr_r   <= 6'd0;
            wb_data_r <= 32'd0;
        end else if (flush) begin
            wb_vld_r  <= 1'b0;
            wb_pr_r   <= 6'd0;
            wb_data_r <= 32'd0;
        end else if (grant_s != 3'b000) begin
            wb_vld_r  <= 1'b1;
            wb_pr_r   <= bpr_r[gidx_s];
            wb_data_r <= bdata_r[gidx_s];
        end else begin
            wb_vld_r  <= 1'b0;
            wb_pr_r   <= 6'd0;
            wb_data_r <= 32'd0;
        end
    end

    assign MUL_rdy = rdy_s[0];
    assign DIV_rdy = rdy_s[1];
    assign LSU_rdy = rdy_s[2];
    assign WB_vld  = wb_vld_r;
    assign WB_PR   = wb_pr_r;
    assign WB_data = wb_data_r;
    assign pending = |bvld_r;

endmodule
